audio_mem_sched: RTL and testbench

//  Scheduler sharing one read-only sample memory (SRAM/SDRAM/flash word port) between the

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_sample_fifo.sv | 54 +++++
 rtl/audio_mem_sched.sv | 157 +++++++++++++++
 tb/tb_audio_mem_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types for the audio/host memory scheduler: access FSM states and grant owner.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_e;

    typedef enum logic {
        AUD,
        HOST
    } owner_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Audio prefetch FIFO: single-word push, two-word pop, synchronous flush.
// The two oldest words are always visible on rd_data0/rd_data1.
module audio_sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop2,
    output logic [DATA_WIDTH-1:0] rd_data0,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [LVL_W-1:0]      level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_nx;

    assign rd_ptr_nx = rd_ptr + 1'b1;
    assign rd_data0  = mem[rd_ptr];
    assign rd_data1  = mem[rd_ptr_nx];

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop2)
                rd_ptr <= rd_ptr + PTR_W'(2);
            // push and pop in one cycle net to level-1
            level <= level + LVL_W'(push) - (pop2 ? LVL_W'(2) : '0);
        end
    end

    always_ff @(posedge iCLK_18_4) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/audio_mem_sched.sv
// Shares one read-only sample memory between audio prefetch and a host requester,
// and hands a stereo L/R pair to the serializer on each frame strobe.
module audio_mem_sched
    import audio_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16,
    parameter int DATA_NUM   = 262144,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WM     = 4
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iAUD_EN,
    input  logic                  iFRAME_STB,
    input  logic                  iCLR_UNDR,
    input  logic                  iHOST_REQ,
    input  logic [ADDR_WIDTH-1:0] iHOST_ADDR,
    output logic                  oHOST_ACK,
    output logic [DATA_WIDTH-1:0] oHOST_DATA,
    output logic                  oMEM_RD,
    output logic [ADDR_WIDTH-1:0] oMEM_ADDR,
    input  logic [DATA_WIDTH-1:0] iMEM_DATA,
    output logic [DATA_WIDTH-1:0] oSMP_L,
    output logic [DATA_WIDTH-1:0] oSMP_R,
    output logic                  oUNDERRUN
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    sched_state_e          state;
    owner_e                owner;
    logic [LAT_W-1:0]      lat_cnt;
    logic [ADDR_WIDTH-1:0] aud_addr;

    logic [LVL_W-1:0]      fifo_level;
    logic [DATA_WIDTH-1:0] fifo_rd0;
    logic [DATA_WIDTH-1:0] fifo_rd1;

    logic                  inflight;
    logic [LVL_W:0]        lvl_sum;
    logic                  aud_elig;
    logic                  aud_urgent;
    logic                  host_ok;
    logic                  capture;
    logic                  push;
    logic                  frame_ok;
    logic                  pop2;

    always_comb begin
        inflight   = (state != IDLE) && (owner == AUD);
        lvl_sum    = {1'b0, fifo_level} + {{LVL_W{1'b0}}, inflight};
        aud_elig   = iAUD_EN && (lvl_sum < (LVL_W + 1)'(FIFO_DEPTH));
        aud_urgent = aud_elig && (fifo_level < LVL_W'(LOW_WM));
        // request is still high during its own ACK cycle; don't serve it twice
        host_ok    = iHOST_REQ && !oHOST_ACK;
        capture    = (state == WAIT) && (lat_cnt == LAT_W'(MEM_LAT - 1));
        push       = capture && (owner == AUD) && iAUD_EN;
        frame_ok   = iFRAME_STB && iAUD_EN;
        pop2       = frame_ok && (fifo_level >= LVL_W'(2));
    end

    audio_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) u_fifo (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .flush     (!iAUD_EN),
        .push      (push),
        .push_data (iMEM_DATA),
        .pop2      (pop2),
        .rd_data0  (fifo_rd0),
        .rd_data1  (fifo_rd1),
        .level     (fifo_level)
    );

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            owner      <= AUD;
            lat_cnt    <= '0;
            aud_addr   <= '0;
            oMEM_RD    <= 1'b0;
            oMEM_ADDR  <= '0;
            oHOST_ACK  <= 1'b0;
            oHOST_DATA <= '0;
        end else begin
            oMEM_RD   <= 1'b0;
            oHOST_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (aud_urgent || (aud_elig && !host_ok)) begin
                        owner     <= AUD;
                        oMEM_RD   <= 1'b1;
                        oMEM_ADDR <= aud_addr;
                        state     <= ISSUE;
                    end else if (host_ok) begin
                        owner     <= HOST;
                        oMEM_RD   <= 1'b1;
                        oMEM_ADDR <= iHOST_ADDR;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    lat_cnt <= '0;
                    if (owner == AUD) begin
                        if (aud_addr == ADDR_WIDTH'(DATA_NUM - 1))
                            aud_addr <= '0;
                        else
                            aud_addr <= aud_addr + 1'b1;
                    end
                end
                WAIT: begin
                    if (capture) begin
                        state <= IDLE;
                        if (owner == HOST) begin
                            oHOST_ACK  <= 1'b1;
                            oHOST_DATA <= iMEM_DATA;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // playback off rewinds the stream; overrides the ISSUE increment
            if (!iAUD_EN)
                aud_addr <= '0;
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            oSMP_L    <= '0;
            oSMP_R    <= '0;
            oUNDERRUN <= 1'b0;
        end else begin
            if (!iAUD_EN) begin
                oSMP_L <= '0;
                oSMP_R <= '0;
            end else if (pop2) begin
                oSMP_L <= fifo_rd0;
                oSMP_R <= fifo_rd1;
            end
            if (frame_ok && !pop2)
                oUNDERRUN <= 1'b1;
            else if (iCLR_UNDR)
                oUNDERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_mem_sched.sv
// Directed bench for audio_mem_sched: default instance plus a DATA_NUM=16 instance
// for address wrap; memory model returns word = address after a 2-cycle latency.
module tb_audio_mem_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aud_en = 1'b0;
    logic        stb = 1'b0;
    logic        clr = 1'b0;
    logic        host_req = 1'b0;
    logic [17:0] host_addr = '0;

    logic        host_ack, mem_rd, undr;
    logic [15:0] host_data, mem_data, smp_l, smp_r;
    logic [17:0] mem_addr;

    logic        host_ack16, mem_rd16, undr16;
    logic [15:0] host_data16, mem_data16, smp_l16, smp_r16;
    logic [17:0] mem_addr16;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] rd_log[$];
    logic [17:0] rd_log16[$];

    always #5 clk = ~clk;

    audio_mem_sched dut (
        .iCLK_18_4 (clk), .iRST_N (rst_n), .iAUD_EN (aud_en), .iFRAME_STB (stb),
        .iCLR_UNDR (clr), .iHOST_REQ (host_req), .iHOST_ADDR (host_addr),
        .oHOST_ACK (host_ack), .oHOST_DATA (host_data), .oMEM_RD (mem_rd),
        .oMEM_ADDR (mem_addr), .iMEM_DATA (mem_data), .oSMP_L (smp_l),
        .oSMP_R (smp_r), .oUNDERRUN (undr)
    );

    audio_mem_sched #(.DATA_NUM(16)) dut16 (
        .iCLK_18_4 (clk), .iRST_N (rst_n), .iAUD_EN (aud_en), .iFRAME_STB (stb),
        .iCLR_UNDR (clr), .iHOST_REQ (host_req), .iHOST_ADDR (host_addr),
        .oHOST_ACK (host_ack16), .oHOST_DATA (host_data16), .oMEM_RD (mem_rd16),
        .oMEM_ADDR (mem_addr16), .iMEM_DATA (mem_data16), .oSMP_L (smp_l16),
        .oSMP_R (smp_r16), .oUNDERRUN (undr16)
    );

    // memory models: data valid exactly 2 cycles after the read strobe, junk otherwise
    logic        v1 = 1'b0, v2 = 1'b0, w1 = 1'b0, w2 = 1'b0;
    logic [17:0] a1 = '0, a2 = '0, b1 = '0, b2 = '0;
    always @(posedge clk) begin
        v1 <= mem_rd;   a1 <= mem_addr;   v2 <= v1; a2 <= a1;
        w1 <= mem_rd16; b1 <= mem_addr16; w2 <= w1; b2 <= b1;
    end
    assign mem_data   = v2 ? a2[15:0] : 16'hDEAD;
    assign mem_data16 = w2 ? b2[15:0] : 16'hDEAD;

    always @(negedge clk) begin
        if (mem_rd)   rd_log.push_back(mem_addr);
        if (mem_rd16) rd_log16.push_back(mem_addr16);
    end

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        u;
    } frame_vec_t;

    frame_vec_t spaced_tab[3];
    frame_vec_t burst_tab[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; aud_en = 1'b0; stb = 1'b0; clr = 1'b0; host_req = 1'b0; host_addr = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic reset_and_fill();
        do_reset();
        aud_en = 1'b1;
        tick(40);
    endtask

    task automatic wait_ack(output int cnt);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            cnt++;
            if (host_ack) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        spaced_tab[0] = '{16'd0, 16'd1, 1'b0};
        spaced_tab[1] = '{16'd2, 16'd3, 1'b0};
        spaced_tab[2] = '{16'd4, 16'd5, 1'b0};
        burst_tab[0]  = '{16'd0, 16'd1, 1'b0};
        burst_tab[1]  = '{16'd2, 16'd3, 1'b0};
        burst_tab[2]  = '{16'd4, 16'd5, 1'b0};
        burst_tab[3]  = '{16'd6, 16'd7, 1'b0};
        for (int i = 4; i < 9; i++) burst_tab[i] = '{16'd6, 16'd7, 1'b1};

        // reset state
        do_reset();
        chk("rst_ack", host_ack, 0);
        chk("rst_hdata", host_data, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_smp", {smp_l, smp_r}, 0);
        chk("rst_undr", undr, 0);

        // fill from empty: exactly addresses 0..7, then quiet
        rd_log.delete();
        aud_en = 1'b1;
        tick(40);
        chk("fill_count", rd_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("fill_addr", rd_log[i], i);
        rd_log.delete();
        tick(40);
        chk("full_no_rd", rd_log.size(), 0);
        chk("full_smp", {smp_l, smp_r}, 0);

        // widely spaced frames
        for (int k = 0; k < 3; k++) begin
            stb = 1'b1; tick(1); stb = 1'b0;
            chk("spaced_l", smp_l, spaced_tab[k].l);
            chk("spaced_r", smp_r, spaced_tab[k].r);
            chk("spaced_undr", undr, spaced_tab[k].u);
            tick(63);
        end

        // back-to-back frames outrun the refill; underrun from the fifth on
        reset_and_fill();
        stb = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick(1);
            chk("burst_l", smp_l, burst_tab[k].l);
            chk("burst_r", smp_r, burst_tab[k].r);
            chk("burst_undr", undr, burst_tab[k].u);
        end
        stb = 1'b0;
        tick(5);
        chk("undr_sticky", undr, 1);
        chk("undr_hold_l", smp_l, 6);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("undr_clear", undr, 0);

        // underrun and clear in the same cycle: underrun wins
        do_reset();
        aud_en = 1'b1; stb = 1'b1; clr = 1'b1;
        tick(1);
        stb = 1'b0; clr = 1'b0;
        chk("undr_vs_clr", undr, 1);
        chk("undr_smp_zero", {smp_l, smp_r}, 0);

        // host request with a full FIFO
        reset_and_fill();
        rd_log.delete();
        host_addr = 18'h01234; host_req = 1'b1;
        wait_ack(cnt);
        chk("host_lat", cnt, 4);
        chk("host_data", host_data, 16'h1234);
        host_req = 1'b0;
        chk("host_rd_addr", rd_log.size() > 0 ? rd_log[0] : 18'h3FFFF, 18'h01234);
        tick(1);
        chk("host_ack_pulse", host_ack, 0);

        // host request with low FIFO waits for refill to the watermark
        reset_and_fill();
        stb = 1'b1; tick(3); stb = 1'b0;
        rd_log.delete();
        host_addr = 18'h01234; host_req = 1'b1;
        wait_ack(cnt);
        host_req = 1'b0;
        chk("host_wait_lat", cnt, 10);
        chk("host_wait_data", host_data, 16'h1234);
        chk("host_wait_nrd", rd_log.size(), 2);
        chk("host_wait_aud", rd_log.size() > 0 ? rd_log[0] : 18'h3FFFF, 9);

        // address wrap with DATA_NUM=16
        do_reset();
        rd_log16.delete();
        aud_en = 1'b1;
        tick(40);
        for (int k = 0; k < 10; k++) begin
            stb = 1'b1; tick(1); stb = 1'b0;
            chk("wrap_l", smp_l16, (2 * k) % 16);
            chk("wrap_r", smp_r16, (2 * k + 1) % 16);
            tick(15);
        end
        chk("wrap_undr", undr16, 0);
        chk("wrap_nrd", rd_log16.size() >= 20, 1);
        for (int i = 0; i < 20; i++) chk("wrap_addr", rd_log16[i], i % 16);

        // playback disabled while an audio read is in WAIT
        reset_and_fill();
        stb = 1'b1; tick(1); stb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd) break;
            tick(1);
        end
        chk("drop_issue_seen", mem_rd, 1);
        tick(1);
        aud_en = 1'b0;
        rd_log.delete();
        tick(4);
        chk("drop_smp", {smp_l, smp_r}, 0);
        chk("drop_no_rd", rd_log.size(), 0);
        stb = 1'b1; tick(1); stb = 1'b0;
        chk("drop_stb_ignored", undr, 0);
        aud_en = 1'b1;
        tick(1);
        chk("restart_rd", mem_rd, 1);
        chk("restart_addr", mem_addr, 0);
        tick(40);
        stb = 1'b1; tick(1); stb = 1'b0;
        chk("restart_l", smp_l, 0);
        chk("restart_r", smp_r, 1);

        // reset in the middle of a host access; held request is served again
        do_reset();
        host_addr = 18'h00ABC; host_req = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_rd", mem_rd, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_ack", host_ack, 0);
        rst_n = 1'b1;
        wait_ack(cnt);
        host_req = 1'b0;
        chk("midrst_lat", cnt, 4);
        chk("midrst_data", host_data, 16'h0ABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
